bin2dpd_seq: RTL

- Sequential binary-to-densely-packed-decimal front end. Sits directly upstream of the DPD decode path and feeds declets onward.
- Accepts an unsigned binary value on a valid/ready handshake.
- Converts it to BCD by iterative shift-and-add-3 (double dabble), one bit per clock.
- Packs each 3-digit BCD group into a 10-bit declet using dpdencode instances.

---
 rtl/bin2dpd_seq_if.sv | 24 ++
 rtl/bin2dpd_seq.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/bin2dpd_seq_if.sv
// rtl/bin2dpd_seq_if.sv - input/output handshake bundle for the binary-to-DPD converter
interface bin2dpd_seq_if #(
   parameter int GROUPS = 2,
   parameter int BIN_W  = 20
);
   logic                   in_valid;
   logic                   in_ready;
   logic [BIN_W-1:0]       bin_in;
   logic                   out_valid;
   logic                   out_ready;
   logic [12*GROUPS-1:0]   bcd_out;
   logic [10*GROUPS-1:0]   dpd_out;
   logic                   out_err;

   modport slave (
      input  in_valid, bin_in, out_ready,
      output in_ready, out_valid, bcd_out, dpd_out, out_err
   );

   modport master (
      output in_valid, bin_in, out_ready,
      input  in_ready, out_valid, bcd_out, dpd_out, out_err
   );
endinterface

// File: rtl/bin2dpd_seq.sv
// rtl/bin2dpd_seq.sv - sequential double-dabble binary-to-BCD converter with DPD declet packing
module dpdencode (
   input  logic [11:0] i_bcd,
   output logic [9:0]  o_dpd
);
   logic w_a, w_b, w_c, w_d, w_e, w_f, w_g, w_h, w_i, w_j, w_k, w_m;

   assign {w_a, w_b, w_c, w_d} = i_bcd[11:8];
   assign {w_e, w_f, w_g, w_h} = i_bcd[7:4];
   assign {w_i, w_j, w_k, w_m} = i_bcd[3:0];

   // Selector is the set of "large" digits (8 or 9) in the group.
   always_comb begin
      o_dpd = '0;
      case ({w_a, w_e, w_i})
         3'b000:  o_dpd = {w_b, w_c, w_d, w_f, w_g, w_h, 1'b0, w_j, w_k, w_m};
         3'b001:  o_dpd = {w_b, w_c, w_d, w_f, w_g, w_h, 1'b1, 2'b00, w_m};
         3'b010:  o_dpd = {w_b, w_c, w_d, w_j, w_k, w_h, 1'b1, 2'b01, w_m};
         3'b011:  o_dpd = {w_b, w_c, w_d, 2'b10, w_h, 1'b1, 2'b11, w_m};
         3'b100:  o_dpd = {w_j, w_k, w_d, w_f, w_g, w_h, 1'b1, 2'b10, w_m};
         3'b101:  o_dpd = {w_f, w_g, w_d, 2'b01, w_h, 1'b1, 2'b11, w_m};
         3'b110:  o_dpd = {w_j, w_k, w_d, 2'b00, w_h, 1'b1, 2'b11, w_m};
         default: o_dpd = {2'b00, w_d, 2'b11, w_h, 1'b1, 2'b11, w_m};
      endcase
   end
endmodule

module bin2dpd_seq #(
   parameter int GROUPS = 2,
   parameter int BIN_W  = 20
) (
   input  logic          clk,
   input  logic          rst_n,
   bin2dpd_seq_if.slave  bus
);
   localparam int BCD_W = 12 * GROUPS;
   localparam int SH_W  = BCD_W + BIN_W;
   localparam int CNT_W = $clog2(BIN_W + 1);

   function automatic longint unsigned pow10(input int n);
      longint unsigned p;
      p = 64'd1;
      for (int k = 0; k < n; k++) p = p * 64'd10;
      return p;
   endfunction

   localparam logic [BIN_W-1:0] MAX_BIN = BIN_W'(pow10(3 * GROUPS) - 64'd1);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

   state_t             r_state, w_next;
   logic [SH_W-1:0]    r_shift, w_adj, w_shifted;
   logic [CNT_W-1:0]   r_cnt;
   logic [BCD_W-1:0]   r_bcd;
   logic               r_err;
   logic [10*GROUPS-1:0] w_dpd;
   logic               w_over, w_last;

   assign w_over = bus.bin_in > MAX_BIN;
   assign w_last = (r_cnt == CNT_W'(1));

   always_comb begin
      w_adj = r_shift;
      for (int d = 0; d < 3 * GROUPS; d++) begin
         if (r_shift[BIN_W + 4*d +: 4] >= 4'd5)
            w_adj[BIN_W + 4*d +: 4] = r_shift[BIN_W + 4*d +: 4] + 4'd3;
      end
   end

   assign w_shifted = w_adj << 1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next        = r_state;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      case (r_state)
         S_IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) w_next = w_over ? S_DONE : S_SHIFT;
         end
         S_SHIFT: begin
            if (w_last) w_next = S_DONE;
         end
         S_DONE: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Results are only rewritten on completion or range error, so they stay
   // stable through backpressure and remain readable (stale) back in IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shift <= '0;
         r_cnt   <= '0;
         r_bcd   <= '0;
         r_err   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.in_valid) begin
                  if (w_over) begin
                     r_bcd <= '0;
                     r_err <= 1'b1;
                  end else begin
                     r_shift <= {{BCD_W{1'b0}}, bus.bin_in};
                     r_cnt   <= CNT_W'(BIN_W);
                  end
               end
            end
            S_SHIFT: begin
               r_shift <= w_shifted;
               r_cnt   <= r_cnt - 1'b1;
               if (w_last) begin
                  r_bcd <= w_shifted[SH_W-1 -: BCD_W];
                  r_err <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   for (genvar g = 0; g < GROUPS; g++) begin : g_enc
      dpdencode u_enc (
         .i_bcd (r_bcd[12*g +: 12]),
         .o_dpd (w_dpd[10*g +: 10])
      );
   end

   assign bus.bcd_out = r_bcd;
   assign bus.dpd_out = w_dpd;
   assign bus.out_err = r_err;
endmodule
